// File: rtl/mac_operand_sequencer_if.sv
// mac_operand_sequencer_if
// Bundles the signals around one MAC operand sequencer: command (start/len/busy),
// the shared operand-memory read port, the MAC operand/accumulator port, and the
// valid/ready result port.
// Modports:
//   master - the sequencer itself (drives rd_*, mac_*, res_valid/res_data, busy)
//   slave  - the surrounding environment (controller, memories, MAC, consumer)
// Build option MAC_SEQ_BASE_EN: adds x_base/w_base command inputs and replaces
// the shared rd_addr with independent x_addr/w_addr read addresses.
interface mac_operand_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 4
) ();
    logic              start;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              rd_en;
`ifdef MAC_SEQ_BASE_EN
    logic [ADDR_W-1:0] x_base;
    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] x_addr;
    logic [ADDR_W-1:0] w_addr;
`else
    logic [ADDR_W-1:0] rd_addr;
`endif
    logic [DATA_W-1:0] x_rdata;
    logic [DATA_W-1:0] w_rdata;
    logic              mac_clr;
    logic              mac_en;
    logic [DATA_W-1:0] mac_x;
    logic [DATA_W-1:0] mac_w;
    logic [ACC_W-1:0]  mac_acc;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;

`ifdef MAC_SEQ_BASE_EN
    modport master (
        input  start, len, x_base, w_base, x_rdata, w_rdata, mac_acc, res_ready,
        output busy, rd_en, x_addr, w_addr, mac_clr, mac_en, mac_x, mac_w,
               res_valid, res_data
    );
    modport slave (
        output start, len, x_base, w_base, x_rdata, w_rdata, mac_acc, res_ready,
        input  busy, rd_en, x_addr, w_addr, mac_clr, mac_en, mac_x, mac_w,
               res_valid, res_data
    );
`else
    modport master (
        input  start, len, x_rdata, w_rdata, mac_acc, res_ready,
        output busy, rd_en, rd_addr, mac_clr, mac_en, mac_x, mac_w,
               res_valid, res_data
    );
    modport slave (
        output start, len, x_rdata, w_rdata, mac_acc, res_ready,
        input  busy, rd_en, rd_addr, mac_clr, mac_en, mac_x, mac_w,
               res_valid, res_data
    );
`endif
endinterface

// File: rtl/mac_operand_sequencer.sv
// mac_operand_sequencer
// Initiator side of the MAC operand interface. On an accepted start it reads
// len (x, w) pairs from two synchronous-read operand memories, one pair per
// cycle, registers them into the MAC operand inputs, then captures the final
// accumulator and offers it on a valid/ready result port.
// Ports:
//   clk    - clock, rising edge
//   reset  - synchronous, active-high
//   bus    - mac_operand_sequencer_if.master:
//            start/len in, busy out          (command)
//            rd_en/rd_addr out, x/w_rdata in (operand memories, 1-cycle read)
//            mac_clr/mac_en/mac_x/mac_w out, mac_acc in (MAC unit)
//            res_valid/res_data out, res_ready in (result consumer)
// Build option MAC_SEQ_BASE_EN: x_base/w_base are latched with start and the
// memories are addressed through x_addr = x_base + index and
// w_addr = w_base + index (modulo 2**ADDR_W) instead of rd_addr.
module mac_operand_sequencer #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 16,
    parameter int ADDR_W = 4
) (
    input logic                    clk,
    input logic                    reset,
    mac_operand_sequencer_if.master bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FLUSH  = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] last_idx;
    logic              rd_valid;
    logic              mac_en_q;
    logic [DATA_W-1:0] mac_x_q;
    logic [DATA_W-1:0] mac_w_q;
    logic              res_valid_q;
    logic [ACC_W-1:0]  res_data_q;
    logic [ADDR_W:0]   len_clamped;
    logic [ADDR_W:0]   len_minus_one;
    logic              accept;
`ifdef MAC_SEQ_BASE_EN
    logic [ADDR_W-1:0] x_base_q;
    logic [ADDR_W-1:0] w_base_q;
`endif

    // Lengths beyond the memory depth are clamped so the index never wraps
    // inside one operation; the stored value is the last index to issue.
    always_comb begin
        len_clamped   = (bus.len > MAX_LEN) ? MAX_LEN : bus.len;
        len_minus_one = len_clamped - LEN_ONE;
        accept        = (state == S_IDLE) && bus.start && (bus.len != '0);
    end

    // Control and datapath. rd_valid marks memory data arriving this cycle;
    // it becomes mac_en one cycle later, alongside the registered operands.
    // FLUSH waits until both pipeline stages are empty, which also gives the
    // MAC one cycle to register its last product before mac_acc is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            last_idx    <= '0;
            rd_valid    <= 1'b0;
            mac_en_q    <= 1'b0;
            mac_x_q     <= '0;
            mac_w_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
`ifdef MAC_SEQ_BASE_EN
            x_base_q    <= '0;
            w_base_q    <= '0;
`endif
        end else begin
            rd_valid <= (state == S_RUN);
            mac_en_q <= rd_valid;
            if (rd_valid) begin
                mac_x_q <= bus.x_rdata;
                mac_w_q <= bus.w_rdata;
            end

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        last_idx <= len_minus_one[ADDR_W-1:0];
                        idx      <= '0;
`ifdef MAC_SEQ_BASE_EN
                        x_base_q <= bus.x_base;
                        w_base_q <= bus.w_base;
`endif
                        state    <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (idx == last_idx) begin
                        idx   <= '0;
                        state <= S_FLUSH;
                    end else begin
                        idx <= idx + ADDR_W'(1);
                    end
                end
                S_FLUSH: begin
                    if (!rd_valid && !mac_en_q) begin
                        res_data_q  <= bus.mac_acc;
                        res_valid_q <= 1'b1;
                        state       <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // The MAC clear coincides with the first read (index 0), two cycles
    // ahead of the first mac_en, so the two never overlap.
    assign bus.busy      = (state != S_IDLE);
    assign bus.rd_en     = (state == S_RUN);
    assign bus.mac_clr   = (state == S_RUN) && (idx == '0);
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_x     = mac_x_q;
    assign bus.mac_w     = mac_w_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
`ifdef MAC_SEQ_BASE_EN
    assign bus.x_addr    = x_base_q + idx;
    assign bus.w_addr    = w_base_q + idx;
`else
    assign bus.rd_addr   = idx;
`endif

endmodule

// File: tb/tb_mac_operand_sequencer.sv
// tb_mac_operand_sequencer
// Self-checking bench for mac_operand_sequencer. Provides behavioural models of
// the two synchronous-read operand memories and of the MAC unit, runs a table
// of directed operations, then hand-written sequences for stall, len=0,
// mid-operation reset, back-to-back starts and (with MAC_SEQ_BASE_EN) bases.
module tb_mac_operand_sequencer;

    localparam int DATA_W = 8;
    localparam int ACC_W  = 16;
    localparam int ADDR_W = 4;

    typedef struct {
        logic [ADDR_W:0]          len;
        logic [15:0][DATA_W-1:0]  xv;
        logic [15:0][DATA_W-1:0]  wv;
        logic [ACC_W-1:0]         exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    logic [DATA_W-1:0] xmem [16];
    logic [DATA_W-1:0] wmem [16];
    logic [ACC_W-1:0]  acc;
    vec_t              vecs [6];

    always #5 clk = ~clk;

    mac_operand_sequencer_if #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

    mac_operand_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Operand memories: data appears the cycle after the read strobe.
    // MAC model: synchronous clear, wrapping ACC_W accumulate when enabled.
    always @(posedge clk) begin
        if (bus.rd_en) begin
`ifdef MAC_SEQ_BASE_EN
            bus.x_rdata <= xmem[bus.x_addr];
            bus.w_rdata <= wmem[bus.w_addr];
`else
            bus.x_rdata <= xmem[bus.rd_addr];
            bus.w_rdata <= wmem[bus.rd_addr];
`endif
        end
        if (reset || bus.mac_clr)
            acc <= '0;
        else if (bus.mac_en)
            acc <= acc + ACC_W'(bus.mac_x) * ACC_W'(bus.mac_w);
    end
    assign bus.mac_acc = acc;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [ADDR_W:0] l);
        bus.start = s;
        bus.len   = l;
    endtask

    task automatic loadMem(input vec_t v);
        for (int i = 0; i < 16; i++) begin
            xmem[i] = v.xv[i];
            wmem[i] = v.wv[i];
        end
    endtask

    // Runs one operation with start in cycle 0 and checks read issue, MAC
    // enable window, clear pulse, result latency/value and the handshake.
    task automatic runOp(input string tag, input vec_t v);
        int lc, n_rd, n_en, n_clr, first_en, last_en, addr_err, vcyc;
        logic got;
        lc = (v.len > 16) ? 16 : int'(v.len);
        n_rd = 0; n_en = 0; n_clr = 0; first_en = -1; last_en = -1;
        addr_err = 0; vcyc = 0; got = 1'b0;
        loadMem(v);
        @(negedge clk);
        applyStimulus(1'b1, v.len);
        for (int cyc = 1; cyc <= 60 && !got; cyc++) begin
            @(negedge clk);
            if (cyc == 1) applyStimulus(1'b0, '0);
            if (bus.rd_en) begin
`ifdef MAC_SEQ_BASE_EN
                if (bus.x_addr !== ADDR_W'(n_rd) || bus.w_addr !== ADDR_W'(n_rd)) addr_err++;
`else
                if (bus.rd_addr !== ADDR_W'(n_rd)) addr_err++;
`endif
                n_rd++;
            end
            if (bus.mac_en) begin
                if (first_en < 0) first_en = cyc;
                last_en = cyc;
                n_en++;
            end
            if (bus.mac_clr) n_clr++;
            if (bus.res_valid) begin
                got  = 1'b1;
                vcyc = cyc;
            end
        end
        checkOutput({tag, " res_seen"},    32'(got),   32'd1);
        checkOutput({tag, " res_cycle"},   vcyc,       lc + 4);
        checkOutput({tag, " res_data"},    32'(bus.res_data), 32'(v.exp_data));
        checkOutput({tag, " rd_count"},    n_rd,       lc);
        checkOutput({tag, " addr_seq"},    addr_err,   0);
        checkOutput({tag, " mac_en_cnt"},  n_en,       lc);
        checkOutput({tag, " mac_en_first"}, first_en,  3);
        checkOutput({tag, " mac_en_last"}, last_en,    lc + 2);
        checkOutput({tag, " mac_clr_cnt"}, n_clr,      1);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checkOutput({tag, " busy_after"},  32'(bus.busy),      32'd0);
        checkOutput({tag, " valid_after"}, 32'(bus.res_valid), 32'd0);
    endtask

    initial begin
        vec_t v;
        logic got;
        int   n_busy, n_rd, n_en, n_valid, n_clr, n_res;
        logic [ACC_W-1:0] results [2];

        reset         = 1'b1;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.res_ready = 1'b0;
        bus.x_rdata   = '0;
        bus.w_rdata   = '0;
`ifdef MAC_SEQ_BASE_EN
        bus.x_base    = '0;
        bus.w_base    = '0;
`endif

        // Directed operations with hand-computed dot products.
        for (int k = 0; k < 6; k++) begin
            vecs[k].len = '0; vecs[k].xv = '0; vecs[k].wv = '0; vecs[k].exp_data = '0;
        end
        vecs[0].len = 5'd4;
        for (int i = 0; i < 4; i++) begin
            vecs[0].xv[i] = 8'(i + 1);
            vecs[0].wv[i] = 8'(i + 5);
        end
        vecs[0].exp_data = 16'd70;
        vecs[1].len = 5'd16;
        for (int i = 0; i < 16; i++) begin
            vecs[1].xv[i] = 8'd255;
            vecs[1].wv[i] = 8'd255;
        end
        vecs[1].exp_data = 16'hE010;
        vecs[2].len = 5'd1; vecs[2].xv[0] = 8'd3; vecs[2].wv[0] = 8'd9;
        vecs[2].exp_data = 16'd27;
        vecs[3].len = 5'd2;
        vecs[3].xv[0] = 8'd1; vecs[3].xv[1] = 8'd1;
        vecs[3].wv[0] = 8'd2; vecs[3].wv[1] = 8'd2;
        vecs[3].exp_data = 16'd4;
        vecs[4].len = 5'd20;
        for (int i = 0; i < 16; i++) begin
            vecs[4].xv[i] = 8'(i + 1);
            vecs[4].wv[i] = 8'd1;
        end
        vecs[4].exp_data = 16'd136;
        vecs[5].len = 5'd3;
        vecs[5].xv[0] = 8'd10; vecs[5].xv[1] = 8'd20; vecs[5].xv[2] = 8'd30;
        vecs[5].wv[0] = 8'd2;  vecs[5].wv[1] = 8'd3;  vecs[5].wv[2] = 8'd4;
        vecs[5].exp_data = 16'd200;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst busy",      32'(bus.busy),      32'd0);
        checkOutput("rst rd_en",     32'(bus.rd_en),     32'd0);
        checkOutput("rst res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("rst res_data",  32'(bus.res_data),  32'd0);

        for (int k = 0; k < 6; k++) begin
            $display("[TB] vector %0d len=%0d", k, vecs[k].len);
            runOp($sformatf("vec%0d", k), vecs[k]);
        end

        // Result stall with start held: result must hold, start must wait.
        $display("[TB] stall sequence");
        loadMem(vecs[0]);
        @(negedge clk);
        applyStimulus(1'b1, 5'd4);
        got = 1'b0;
        for (int cyc = 1; cyc <= 30 && !got; cyc++) begin
            @(negedge clk);
            got = bus.res_valid;
        end
        checkOutput("stall res_seen", 32'(got), 32'd1);
        n_valid = 0; n_busy = 0;
        for (int s = 0; s < 5; s++) begin
            if (bus.res_valid === 1'b1 && bus.res_data === 16'd70) n_valid++;
            if (bus.busy === 1'b1) n_busy++;
            if (s < 4) @(negedge clk);
        end
        checkOutput("stall held_cycles", n_valid, 5);
        checkOutput("stall busy_cycles", n_busy, 5);
        @(negedge clk);
        checkOutput("stall still_held", 32'(bus.res_data), 32'd70);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        checkOutput("stall hs busy",  32'(bus.busy),      32'd0);
        checkOutput("stall hs valid", 32'(bus.res_valid), 32'd0);
        checkOutput("stall hs rd_en", 32'(bus.rd_en),     32'd0);
        @(negedge clk);
        applyStimulus(1'b0, '0);
        checkOutput("stall restart busy",    32'(bus.busy),    32'd1);
        checkOutput("stall restart rd_en",   32'(bus.rd_en),   32'd1);
        checkOutput("stall restart mac_clr", 32'(bus.mac_clr), 32'd1);
        got = 1'b0;
        for (int cyc = 1; cyc <= 30 && !got; cyc++) begin
            @(negedge clk);
            got = bus.res_valid;
        end
        checkOutput("stall second res_seen", 32'(got), 32'd1);
        checkOutput("stall second res_data", 32'(bus.res_data), 32'd70);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;

        // start with len=0 is ignored.
        $display("[TB] len=0 sequence");
        @(negedge clk);
        applyStimulus(1'b1, '0);
        n_busy = 0; n_rd = 0; n_en = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            @(negedge clk);
            n_busy += int'(bus.busy);
            n_rd   += int'(bus.rd_en);
            n_en   += int'(bus.mac_en);
        end
        applyStimulus(1'b0, '0);
        checkOutput("len0 busy",   n_busy, 0);
        checkOutput("len0 rd_en",  n_rd,   0);
        checkOutput("len0 mac_en", n_en,   0);

        // Reset during RUN of a len=8 operation aborts it with no result.
        $display("[TB] mid-operation reset sequence");
        for (int i = 0; i < 16; i++) begin
            xmem[i] = 8'd1;
            wmem[i] = 8'd1;
        end
        @(negedge clk);
        applyStimulus(1'b1, 5'd8);
        for (int cyc = 1; cyc <= 3; cyc++) begin
            @(negedge clk);
            if (cyc == 1) applyStimulus(1'b0, '0);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("abort busy",      32'(bus.busy),      32'd0);
        checkOutput("abort rd_en",     32'(bus.rd_en),     32'd0);
        checkOutput("abort mac_en",    32'(bus.mac_en),    32'd0);
        checkOutput("abort mac_clr",   32'(bus.mac_clr),   32'd0);
        checkOutput("abort mac_x",     32'(bus.mac_x),     32'd0);
        checkOutput("abort mac_w",     32'(bus.mac_w),     32'd0);
        checkOutput("abort res_data",  32'(bus.res_data),  32'd0);
        checkOutput("abort res_valid", 32'(bus.res_valid), 32'd0);
        n_valid = 0; n_busy = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            n_valid += int'(bus.res_valid);
            n_busy  += int'(bus.busy);
        end
        checkOutput("abort no_result", n_valid, 0);
        checkOutput("abort idle",      n_busy,  0);
        v = vecs[2];
        runOp("after_abort", v);

        // Back-to-back operations with start held and consumer always ready.
        $display("[TB] back-to-back sequence");
        loadMem(vecs[3]);
        bus.res_ready = 1'b1;
        n_clr = 0; n_res = 0;
        results[0] = '0; results[1] = '0;
        @(negedge clk);
        applyStimulus(1'b1, 5'd2);
        for (int cyc = 1; cyc <= 40 && n_res < 2; cyc++) begin
            @(negedge clk);
            n_clr += int'(bus.mac_clr);
            if (bus.res_valid) begin
                results[n_res] = bus.res_data;
                n_res++;
                if (n_res == 1) begin
                    for (int i = 0; i < 2; i++) begin
                        xmem[i] = 8'd3;
                        wmem[i] = 8'd4;
                    end
                end else begin
                    applyStimulus(1'b0, '0);
                end
            end
        end
        @(negedge clk);
        bus.res_ready = 1'b0;
        checkOutput("b2b results",  n_res, 2);
        checkOutput("b2b first",    32'(results[0]), 32'd4);
        checkOutput("b2b second",   32'(results[1]), 32'd24);
        checkOutput("b2b mac_clr",  n_clr, 2);
        checkOutput("b2b idle",     32'(bus.busy), 32'd0);

`ifdef MAC_SEQ_BASE_EN
        // Independent bases, x wrapping past the top of memory.
        $display("[TB] base address sequence");
        for (int i = 0; i < 16; i++) begin
            xmem[i] = '0;
            wmem[i] = '0;
        end
        xmem[14] = 8'd1; xmem[15] = 8'd2; xmem[0] = 8'd3;
        wmem[2]  = 8'd4; wmem[3]  = 8'd5; wmem[4] = 8'd6;
        @(negedge clk);
        bus.x_base = 4'd14;
        bus.w_base = 4'd2;
        applyStimulus(1'b1, 5'd3);
        @(negedge clk);
        applyStimulus(1'b0, '0);
        bus.x_base = '0;
        bus.w_base = '0;
        checkOutput("base x_addr0", 32'(bus.x_addr), 32'd14);
        checkOutput("base w_addr0", 32'(bus.w_addr), 32'd2);
        @(negedge clk);
        checkOutput("base x_addr1", 32'(bus.x_addr), 32'd15);
        checkOutput("base w_addr1", 32'(bus.w_addr), 32'd3);
        @(negedge clk);
        checkOutput("base x_addr2", 32'(bus.x_addr), 32'd0);
        checkOutput("base w_addr2", 32'(bus.w_addr), 32'd4);
        got = 1'b0;
        for (int cyc = 1; cyc <= 20 && !got; cyc++) begin
            @(negedge clk);
            got = bus.res_valid;
        end
        checkOutput("base res_seen", 32'(got), 32'd1);
        checkOutput("base res_data", 32'(bus.res_data), 32'd32);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
